spi_slave_bridge: RTL and testbench
===================================

SPI_SLAVE_BRIDGE -- requirements
Module: spi_slave_bridge

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of CLK_I flops on SPI_CLK, SPI_CS_N and SPI_MOSI, legal range 2..3.
REQ-002 Parameter MISO_IDLE, default 1'b0: value driven on SPI_MISO while no read data is being shifted.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 CLK_I  input  1  system clock; all logic on rising edge.
REQ-005 RST_I  input  1  synchronous active-high reset.
REQ-006 SPI_CLK  input  1  serial clock from master, mode 0 (CPOL=0, CPHA=0).
REQ-007 SPI_CS_N  input  1  chip select, active low, frames a transaction.
REQ-008 SPI_MOSI  input  1  serial data from master, MSB first.
REQ-009 SPI_MISO  output  1  serial data to master, MSB first.
REQ-010 SPI_MISO_OE  output  1  high while SPI_CS_N (synchronized) is low.
REQ-011 REG_ADR  output  7  register address decoded from the command byte.
REQ-012 REG_WE  output  1  one-cycle write strobe.
REQ-013 REG_DAT_O  output  32  write data, valid while REG_WE is high.
REQ-014 REG_RD  output  1  one-cycle read request.
REQ-015 REG_DAT_I  input  32  read data, sampled exactly 1 CLK_I after REG_RD.
REQ-016 FRAME_ERR  output  1  one-cycle pulse on an aborted frame.

Function
REQ-017 Frame format: 8-bit command {RW, ADR[6:0]} (RW=1 write, RW=0 read), then 32 data bits; 40 SPI_CLK rising edges total.
REQ-018 Inputs SHALL pass through SYNC_STAGES flops; rise/fall of SPI_CLK is detected on synchronized values; the block requires f(CLK_I) >= 8 x f(SPI_CLK).
REQ-019 MOSI SHALL be sampled on each detected SPI_CLK rise; MISO SHALL change only on a detected SPI_CLK fall.
REQ-020 FSM states: IDLE, CMD, WR_DATA, RD_DATA, WAIT_CS.
REQ-021 IDLE -> CMD on synchronized SPI_CS_N falling; bit counter cleared to 0.
REQ-022 CMD -> WR_DATA or RD_DATA after the 8th rise; REG_ADR is loaded in that same cycle.
REQ-023 On entering RD_DATA, REG_RD SHALL pulse 1 cycle; REG_DAT_I is captured into the shift register on the next cycle.
REQ-024 In RD_DATA, SPI_MISO SHALL present data bit 31 after the first SPI_CLK fall, then one bit per fall.
REQ-025 In WR_DATA, after the 32nd data rise, REG_DAT_O SHALL be loaded and REG_WE SHALL pulse 1 cycle, 1 CLK_I after that rise is detected.
REQ-026 After 40 rises, the FSM enters WAIT_CS; further SPI_CLK edges are ignored and SPI_MISO = MISO_IDLE.
REQ-027 SPI_CS_N rising in any state returns the FSM to IDLE.
REQ-028 If that rise occurs in CMD, WR_DATA or RD_DATA, FRAME_ERR SHALL pulse 1 cycle and no REG_WE is issued.
REQ-029 SPI_MISO = MISO_IDLE in IDLE, CMD and WAIT_CS.
REQ-030 REG_WE and REG_RD SHALL never be high in the same cycle; at most one of them per frame.
REQ-031 SPI_CS_N falling in WAIT_CS or IDLE in the same cycle as another edge: CS SHALL take priority, and the SPI_CLK edge is ignored.

Reset
REQ-032 While RST_I is high: FSM = IDLE, counters and shift registers = 0, synchronizer flops preset to SPI_CLK=0, SPI_CS_N=1, SPI_MOSI=0.
REQ-033 While RST_I is high: SPI_MISO = MISO_IDLE, SPI_MISO_OE = 0, REG_WE = REG_RD = FRAME_ERR = 0, REG_ADR = 0, REG_DAT_O = 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame silently (no FRAME_ERR).
REQ-035 After reset release with SPI_CS_N already low, the block SHALL wait in IDLE for a fresh CS_N fall.

Structure
REQ-036 A shared package spi_pkg SHALL hold the FSM state enum, CMD_BITS=8, DATA_BITS=32, ADR_W=7, and the RW bit index 7.
REQ-037 One sub-module, spi_sync_edge, SHALL implement the synchronizer chain plus rise/fall detection, instanced once per input.

Verification
REQ-038 Write frame: cmd 0x85, data 0xDEADBEEF -> one REG_WE with REG_ADR=0x05 and REG_DAT_O=0xDEADBEEF; REG_RD never asserted.
REQ-039 Read frame: cmd 0x12, REG_DAT_I=0xA5A5_0F0F one cycle after REG_RD -> master receives 0xA5A50F0F and REG_ADR=0x12.
REQ-040 Abort: cmd 0x83 followed by 16 data bits, then CS_N high -> FRAME_ERR pulses once, no REG_WE, FSM back in IDLE.
REQ-041 Overrun: write frame with 48 clocks -> exactly one REG_WE for the first 32 data bits; MISO stays MISO_IDLE for the extra 8.
REQ-042 Reset at bit 20 of a read, then a clean write of 0x01/0x00000001 -> no FRAME_ERR; one REG_WE with correct data.
REQ-043 Ratio corner: f(CLK_I)/f(SPI_CLK)=8 with back-to-back frames and CS_N high for 2 SPI periods -> all frames decode correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave register bridge: frame geometry,
// command byte layout and the controller state encoding.
package spi_pkg;

    localparam int CMD_BITS   = 8;
    localparam int DATA_BITS  = 32;
    localparam int ADR_W      = 7;
    localparam int RW_BIT     = 7;
    localparam int FRAME_BITS = CMD_BITS + DATA_BITS;
    localparam int CNT_W      = 6;

    // Rise counter values that close the command byte and the whole frame.
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_WAIT_CS = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, plus rise/fall
// detection on the synchronized level. The reset value presets every flop
// so no false edge is reported while reset is held.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the raw pin through the synchronizer chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din_i};
        end
    end

    // Remember the previous synchronized level for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_bridge.sv
// SPI mode-0 slave that turns 40-bit frames {RW, ADR[6:0], DATA[31:0]}
// into single-cycle register write strobes or read requests.
module spi_slave_bridge
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic MISO_IDLE   = 1'b0
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        SPI_CLK,
    input  logic        SPI_CS_N,
    input  logic        SPI_MOSI,
    output logic        SPI_MISO,
    output logic        SPI_MISO_OE,
    output logic [6:0]  REG_ADR,
    output logic        REG_WE,
    output logic [31:0] REG_DAT_O,
    output logic        REG_RD,
    input  logic [31:0] REG_DAT_I,
    output logic        FRAME_ERR
);

    // Pin order in the synchronizer vectors: 0 = SPI_CLK, 1 = SPI_CS_N, 2 = SPI_MOSI.
    localparam logic [2:0] SYNC_RST = 3'b010;
    // Edges are trusted only once every flop of the chain, including the
    // edge-detect flop, holds a real post-reset sample.
    localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

    logic [2:0] pin_raw;
    logic [2:0] lvl_w;
    logic [2:0] rise_w;
    logic [2:0] fall_w;

    assign pin_raw = {SPI_MOSI, SPI_CS_N, SPI_CLK};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            spi_sync_edge #(
                .STAGES    (SYNC_STAGES),
                .RESET_VAL (SYNC_RST[gi])
            ) u_sync (
                .clk_i   (CLK_I),
                .rst_i   (RST_I),
                .din_i   (pin_raw[gi]),
                .level_o (lvl_w[gi]),
                .rise_o  (rise_w[gi]),
                .fall_o  (fall_w[gi])
            );
        end
    endgenerate

    logic sync_unused;
    assign sync_unused = ^{lvl_w[0], rise_w[2], fall_w[2]};

    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;
    logic mosi_bit;
    logic edge_ok;

    assign sclk_rise = rise_w[0];
    assign sclk_fall = fall_w[0];
    assign cs_rise   = rise_w[1];
    assign cs_fall   = fall_w[1];
    assign mosi_bit  = lvl_w[2];

    spi_state_e       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [6:0]       cmd_sr_q,  cmd_sr_d;
    logic [31:0]      din_sr_q,  din_sr_d;
    logic [31:0]      dout_sr_q, dout_sr_d;
    logic             miso_q,    miso_d;
    logic [6:0]       adr_q,     adr_d;
    logic [31:0]      dat_o_q,   dat_o_d;
    logic             we_q,      we_d;
    logic             rd_q,      rd_d;
    logic             cap_q,     cap_d;
    logic             err_q,     err_d;
    logic [2:0]       warm_q,    warm_d;

    logic [CMD_BITS-1:0]  cmd_byte;
    logic [DATA_BITS-1:0] din_next;

    assign edge_ok  = (warm_q == WARM_DONE);
    assign cmd_byte = {cmd_sr_q, mosi_bit};
    assign din_next = {din_sr_q[DATA_BITS-2:0], mosi_bit};

    // Frame controller: CS edges take precedence over SPI_CLK edges.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_sr_d  = cmd_sr_q;
        din_sr_d  = din_sr_q;
        dout_sr_d = dout_sr_q;
        miso_d    = miso_q;
        adr_d     = adr_q;
        dat_o_d   = dat_o_q;
        we_d      = 1'b0;
        rd_d      = 1'b0;
        err_d     = 1'b0;
        cap_d     = rd_q;
        warm_d    = edge_ok ? warm_q : warm_q + 3'd1;

        // Read data arrives one cycle after the request pulse.
        if (cap_q) begin
            dout_sr_d = REG_DAT_I;
        end

        if (edge_ok) begin
            if (cs_rise) begin
                state_d = ST_IDLE;
                miso_d  = MISO_IDLE;
                cap_d   = 1'b0;
                if (state_q == ST_CMD || state_q == ST_WR_DATA || state_q == ST_RD_DATA) begin
                    err_d = 1'b1;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state_d  = ST_CMD;
                            cnt_d    = '0;
                            cmd_sr_d = '0;
                            din_sr_d = '0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            cnt_d    = cnt_q + 6'd1;
                            cmd_sr_d = cmd_byte[6:0];
                            if (cnt_q == CMD_LAST) begin
                                adr_d = cmd_byte[ADR_W-1:0];
                                if (cmd_byte[RW_BIT]) begin
                                    state_d = ST_WR_DATA;
                                end else begin
                                    state_d = ST_RD_DATA;
                                    rd_d    = 1'b1;
                                end
                            end
                        end
                    end
                    ST_WR_DATA, ST_RD_DATA: begin
                        if (sclk_rise) begin
                            cnt_d    = cnt_q + 6'd1;
                            din_sr_d = din_next;
                            if (cnt_q == FRAME_LAST) begin
                                state_d = ST_WAIT_CS;
                                miso_d  = MISO_IDLE;
                                if (state_q == ST_WR_DATA) begin
                                    we_d    = 1'b1;
                                    dat_o_d = din_next;
                                end
                            end
                        end else if (sclk_fall && state_q == ST_RD_DATA) begin
                            miso_d    = dout_sr_q[DATA_BITS-1];
                            dout_sr_d = {dout_sr_q[DATA_BITS-2:0], 1'b0};
                        end
                    end
                    default: begin
                        // WAIT_CS: SPI_CLK activity is ignored until CS releases.
                    end
                endcase
            end
        end
    end

    // Register the controller state; reset aborts any frame without an error pulse.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cmd_sr_q  <= '0;
            din_sr_q  <= '0;
            dout_sr_q <= '0;
            miso_q    <= MISO_IDLE;
            adr_q     <= '0;
            dat_o_q   <= '0;
            we_q      <= 1'b0;
            rd_q      <= 1'b0;
            cap_q     <= 1'b0;
            err_q     <= 1'b0;
            warm_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_sr_q  <= cmd_sr_d;
            din_sr_q  <= din_sr_d;
            dout_sr_q <= dout_sr_d;
            miso_q    <= miso_d;
            adr_q     <= adr_d;
            dat_o_q   <= dat_o_d;
            we_q      <= we_d;
            rd_q      <= rd_d;
            cap_q     <= cap_d;
            err_q     <= err_d;
            warm_q    <= warm_d;
        end
    end

    assign SPI_MISO    = miso_q;
    assign SPI_MISO_OE = ~lvl_w[1];
    assign REG_ADR     = adr_q;
    assign REG_WE      = we_q;
    assign REG_DAT_O   = dat_o_q;
    assign REG_RD      = rd_q;
    assign FRAME_ERR   = err_q;

endmodule

// File: tb/tb_spi_slave_bridge.sv
// Directed bench for spi_slave_bridge: a bit-banged SPI master drives
// frames, expected register accesses go into scoreboard queues, and a
// monitor pops and compares them as the bridge issues strobes.
module tb_spi_slave_bridge;
    import spi_pkg::*;

    localparam logic IDLE_BIT = 1'b0;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic        SPI_CLK = 1'b0;
    logic        SPI_CS_N = 1'b1;
    logic        SPI_MOSI = 1'b0;
    logic        SPI_MISO;
    logic        SPI_MISO_OE;
    logic [6:0]  REG_ADR;
    logic        REG_WE;
    logic [31:0] REG_DAT_O;
    logic        REG_RD;
    logic [31:0] REG_DAT_I = 32'h0;
    logic        FRAME_ERR;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int rd_cnt = 0;
    int err_cnt = 0;

    logic [31:0] rd_val = 32'h0;
    logic [38:0] exp_wr[$];
    logic [6:0]  exp_rd[$];

    spi_slave_bridge #(
        .SYNC_STAGES (2),
        .MISO_IDLE   (IDLE_BIT)
    ) dut (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .SPI_CLK     (SPI_CLK),
        .SPI_CS_N    (SPI_CS_N),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_MISO    (SPI_MISO),
        .SPI_MISO_OE (SPI_MISO_OE),
        .REG_ADR     (REG_ADR),
        .REG_WE      (REG_WE),
        .REG_DAT_O   (REG_DAT_O),
        .REG_RD      (REG_RD),
        .REG_DAT_I   (REG_DAT_I),
        .FRAME_ERR   (FRAME_ERR)
    );

    always #5 CLK_I = ~CLK_I;

    // Register file model: read data valid only in the cycle after REG_RD.
    always @(posedge CLK_I) begin
        REG_DAT_I <= REG_RD ? rd_val : 32'hBAD0_BAD0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Monitor: pop scoreboard entries as strobes appear.
    always @(negedge CLK_I) begin
        if (!RST_I) begin
            if (REG_WE || REG_RD) begin
                chk("we_rd_exclusive", 32'(REG_WE & REG_RD), 32'h0);
            end
            if (REG_WE) begin
                we_cnt++;
                chk("we_expected", 32'(exp_wr.size() != 0), 32'h1);
                if (exp_wr.size() != 0) begin
                    logic [38:0] e;
                    e = exp_wr.pop_front();
                    chk("we_adr", 32'(REG_ADR), 32'(e[38:32]));
                    chk("we_dat", REG_DAT_O, e[31:0]);
                    $display("WR adr=0x%02h dat=0x%08h", REG_ADR, REG_DAT_O);
                end
            end
            if (REG_RD) begin
                rd_cnt++;
                chk("rd_expected", 32'(exp_rd.size() != 0), 32'h1);
                if (exp_rd.size() != 0) begin
                    logic [6:0] a;
                    a = exp_rd.pop_front();
                    chk("rd_adr", 32'(REG_ADR), 32'(a));
                    $display("RD adr=0x%02h", REG_ADR);
                end
            end
            if (FRAME_ERR) begin
                err_cnt++;
                $display("FRAME_ERR pulse");
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK_I);
    endtask

    // Bit-banged mode-0 master. rst_at >= 0 pulses reset before that bit
    // and stops clocking; bits past 40 send zeros and collect MISO into extra.
    task automatic spi_xfer(input logic [7:0] cmd, input logic [31:0] wdat,
                            input int nclk, input int half, input int rst_at,
                            input int gap, output logic [31:0] rdat,
                            output logic [7:0] extra);
        logic [39:0] fr;
        fr = {cmd, wdat};
        rdat = 32'h0;
        extra = 8'h0;
        SPI_CS_N = 1'b0;
        wait_clk(half);
        for (int i = 0; i < nclk; i++) begin
            if (i == rst_at) begin
                RST_I = 1'b1;
                wait_clk(4);
                RST_I = 1'b0;
                wait_clk(6);
                chk("post_rst_idle", 32'(dut.state_q), 32'(ST_IDLE));
                break;
            end
            SPI_MOSI = (i < 40) ? fr[39 - i] : 1'b0;
            wait_clk(half);
            SPI_CLK = 1'b1;
            if (i >= 8 && i < 40) rdat = {rdat[30:0], SPI_MISO};
            else if (i >= 40) extra = {extra[6:0], SPI_MISO};
            wait_clk(half);
            SPI_CLK = 1'b0;
        end
        wait_clk(half);
        SPI_CS_N = 1'b1;
        wait_clk(gap);
        $display("XFER cmd=0x%02h wdat=0x%08h clocks=%0d miso=0x%08h", cmd, wdat, nclk, rdat);
    endtask

    initial begin
        logic [31:0] rdat;
        logic [7:0]  extra;
        int we0, rd0, er0;

        // Reset state.
        wait_clk(5);
        chk("rst_miso", 32'(SPI_MISO), 32'(IDLE_BIT));
        chk("rst_oe", 32'(SPI_MISO_OE), 32'h0);
        chk("rst_strobes", 32'({REG_WE, REG_RD, FRAME_ERR}), 32'h0);
        chk("rst_adr", 32'(REG_ADR), 32'h0);
        chk("rst_dat_o", REG_DAT_O, 32'h0);
        RST_I = 1'b0;
        wait_clk(10);

        // Write frame.
        we0 = we_cnt; rd0 = rd_cnt; er0 = err_cnt;
        exp_wr.push_back({7'h05, 32'hDEADBEEF});
        spi_xfer(8'h85, 32'hDEADBEEF, 40, 8, -1, 20, rdat, extra);
        chk("wr_we_count", 32'(we_cnt - we0), 32'h1);
        chk("wr_rd_count", 32'(rd_cnt - rd0), 32'h0);
        chk("wr_miso_idle", rdat, 32'h0);
        chk("wr_q_empty", 32'(exp_wr.size()), 32'h0);

        // Read frame.
        we0 = we_cnt; rd0 = rd_cnt;
        rd_val = 32'hA5A5_0F0F;
        exp_rd.push_back(7'h12);
        spi_xfer(8'h12, 32'h0, 40, 8, -1, 20, rdat, extra);
        chk("rd_data", rdat, 32'hA5A5_0F0F);
        chk("rd_reg_adr", 32'(REG_ADR), 32'h12);
        chk("rd_rd_count", 32'(rd_cnt - rd0), 32'h1);
        chk("rd_we_count", 32'(we_cnt - we0), 32'h0);
        chk("rd_miso_idle_after", 32'(SPI_MISO), 32'(IDLE_BIT));

        // Aborted write frame: 8 command bits + 16 data bits.
        we0 = we_cnt; er0 = err_cnt;
        spi_xfer(8'h83, 32'h1234_5678, 24, 8, -1, 20, rdat, extra);
        chk("abort_err_count", 32'(err_cnt - er0), 32'h1);
        chk("abort_we_count", 32'(we_cnt - we0), 32'h0);
        chk("abort_idle", 32'(dut.state_q), 32'(ST_IDLE));
        chk("abort_oe", 32'(SPI_MISO_OE), 32'h0);

        // Overrun write frame: 48 clocks.
        we0 = we_cnt; er0 = err_cnt;
        exp_wr.push_back({7'h20, 32'h1234_5678});
        spi_xfer(8'hA0, 32'h1234_5678, 48, 8, -1, 20, rdat, extra);
        chk("ovr_we_count", 32'(we_cnt - we0), 32'h1);
        chk("ovr_extra_miso", 32'(extra), 32'h0);
        chk("ovr_err_count", 32'(err_cnt - er0), 32'h0);
        chk("ovr_q_empty", 32'(exp_wr.size()), 32'h0);

        // Reset at bit 20 of a read, CS still low across reset release.
        er0 = err_cnt; we0 = we_cnt;
        rd_val = 32'h0BAD_CAFE;
        exp_rd.push_back(7'h44);
        spi_xfer(8'h44, 32'h0, 40, 8, 20, 20, rdat, extra);
        chk("rst_mid_err", 32'(err_cnt - er0), 32'h0);
        exp_wr.push_back({7'h01, 32'h0000_0001});
        spi_xfer(8'h81, 32'h0000_0001, 40, 8, -1, 20, rdat, extra);
        chk("rst_then_we", 32'(we_cnt - we0), 32'h1);
        chk("rst_then_err", 32'(err_cnt - er0), 32'h0);

        // Ratio 8 (half period 4), back-to-back frames, CS high 2 SPI periods.
        we0 = we_cnt; rd0 = rd_cnt; er0 = err_cnt;
        exp_wr.push_back({7'h05, 32'h0BAD_F00D});
        spi_xfer(8'h85, 32'h0BAD_F00D, 40, 4, -1, 16, rdat, extra);
        rd_val = 32'h5A5A_1234;
        exp_rd.push_back(7'h33);
        spi_xfer(8'h33, 32'h0, 40, 4, -1, 16, rdat, extra);
        chk("fast_rd_data", rdat, 32'h5A5A_1234);
        exp_wr.push_back({7'h7F, 32'hFFFF_0000});
        spi_xfer(8'hFF, 32'hFFFF_0000, 40, 4, -1, 16, rdat, extra);
        rd_val = 32'h8000_0001;
        exp_rd.push_back(7'h00);
        spi_xfer(8'h00, 32'h0, 40, 4, -1, 16, rdat, extra);
        chk("fast_rd_data2", rdat, 32'h8000_0001);
        chk("fast_we_count", 32'(we_cnt - we0), 32'h2);
        chk("fast_rd_count", 32'(rd_cnt - rd0), 32'h2);
        chk("fast_err_count", 32'(err_cnt - er0), 32'h0);
        chk("final_wr_q_empty", 32'(exp_wr.size()), 32'h0);
        chk("final_rd_q_empty", 32'(exp_rd.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
